// File: rtl/hr_pkg.sv
// Shared types and constant helpers for the heart-rate monitor.
package hr_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_INST = 2'd1,
    DIV_AVG  = 2'd2,
    DONE     = 2'd3
  } hr_state_e;

  // Divider width: wide enough for the largest dividend (averaged case)
  function automatic int unsigned calc_dw(input int unsigned fs_hz, input int unsigned navg);
    return $clog2(60 * fs_hz * navg + 1);
  endfunction

  // Dividend for instantaneous BPM: 60 s * sample rate
  function automatic int unsigned calc_hr_dividend(input int unsigned fs_hz);
    return 60 * fs_hz;
  endfunction

  // Dividend for averaged BPM: scaled by the window depth
  function automatic int unsigned calc_hr_avg_dividend(input int unsigned fs_hz,
                                                       input int unsigned navg);
    return 60 * fs_hz * navg;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per enabled cycle.
// done/quotient are combinational: they present the result of the final
// step during the cycle that step executes, so the caller can chain a new
// start on the same edge.
module seq_divider #(
  parameter int unsigned DW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quotient
);

  localparam int unsigned CW = $clog2(DW + 1);

  logic [DW-1:0] rem;
  logic [DW-1:0] q;
  logic [DW-1:0] dvs;
  logic [CW-1:0] cnt;

  logic [DW:0]   trial;
  logic [DW:0]   diff;
  logic          ge;
  logic [DW-1:0] rem_nxt;
  logic [DW-1:0] q_nxt;

  // One restoring step: shift in next dividend bit, subtract if it fits
  always_comb begin
    trial   = {rem, q[DW-1]};
    diff    = trial - {1'b0, dvs};
    ge      = (trial >= {1'b0, dvs});
    rem_nxt = ge ? diff[DW-1:0] : trial[DW-1:0];
    q_nxt   = {q[DW-2:0], ge};
  end

  assign done     = en && (cnt == CW'(1));
  assign quotient = q_nxt;

  // Operand load on start, otherwise iterate until the count runs out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      q   <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (en) begin
      if (start) begin
        rem <= '0;
        q   <= dividend;
        dvs <= divisor;
        cnt <= CW'(DW);
      end else if (cnt != '0) begin
        rem <= rem_nxt;
        q   <= q_nxt;
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/hr_monitor.sv
// Heart-rate post-processing: RR range check, sliding window, BPM division
// and brady/tachy alarms from the window-averaged rate.
module hr_monitor
  import hr_pkg::*;
#(
  parameter int unsigned RR_WIDTH  = 11,
  parameter int unsigned FS_HZ     = 360,
  parameter int unsigned NAVG      = 8,
  parameter int unsigned HR_WIDTH  = 9,
  parameter int unsigned RR_MIN    = 72,
  parameter int unsigned RR_MAX    = 1080,
  parameter int unsigned BRADY_BPM = 50,
  parameter int unsigned TACHY_BPM = 120
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  input  logic                i_ce,
  input  logic [RR_WIDTH-1:0] i_rr_period,
  input  logic                i_rr_period_updated,
  input  logic                i_alg_active,
  output logic [HR_WIDTH-1:0] o_hr_bpm,
  output logic [HR_WIDTH-1:0] o_hr_avg_bpm,
  output logic                o_hr_valid,
  output logic                o_hr_avg_valid,
  output logic                o_brady,
  output logic                o_tachy,
  output logic                o_rr_rejected,
  output logic                o_busy
);

  localparam int unsigned DW              = calc_dw(FS_HZ, NAVG);
  localparam int unsigned HR_DIVIDEND     = calc_hr_dividend(FS_HZ);
  localparam int unsigned HR_AVG_DIVIDEND = calc_hr_avg_dividend(FS_HZ, NAVG);
  localparam int unsigned AW              = $clog2(NAVG);
  localparam int unsigned SW              = RR_WIDTH + AW;
  localparam int unsigned FW              = $clog2(NAVG + 1);
  localparam int unsigned HR_MAX          = (1 << HR_WIDTH) - 1;

  hr_state_e           state;
  logic [RR_WIDTH-1:0] rr_buf [NAVG];
  logic [AW-1:0]       wr_ptr;
  logic [SW-1:0]       sum;
  logic [FW-1:0]       fill;
  logic [DW-1:0]       inst_q;

  logic                full;
  logic [RR_WIDTH-1:0] oldest;
  logic                in_range;
  logic                accept;
  logic                div_start;
  logic [DW-1:0]       div_dividend;
  logic [DW-1:0]       div_divisor;
  logic                div_done;
  logic [DW-1:0]       div_quot;
  logic [HR_WIDTH-1:0] avg_new;

  // Saturate a raw quotient into the BPM output range
  function automatic logic [HR_WIDTH-1:0] sat_hr(input logic [DW-1:0] qv);
    return (qv > DW'(HR_MAX)) ? HR_WIDTH'(HR_MAX) : qv[HR_WIDTH-1:0];
  endfunction

  // Window status and acceptance decode for the incoming strobe
  always_comb begin
    full     = (fill == FW'(NAVG));
    oldest   = full ? rr_buf[wr_ptr] : '0;
    in_range = (i_rr_period >= RR_WIDTH'(RR_MIN)) && (i_rr_period <= RR_WIDTH'(RR_MAX));
    accept   = i_ce && i_alg_active && i_rr_period_updated && (state == IDLE) && in_range;
    avg_new  = sat_hr(div_quot);
  end

  // Divider launch: instantaneous on accept, averaged when the first one ends
  always_comb begin
    div_start    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    if (accept) begin
      div_start    = 1'b1;
      div_dividend = DW'(HR_DIVIDEND);
      div_divisor  = DW'(i_rr_period);
    end else if (i_ce && i_alg_active && (state == DIV_INST) && div_done) begin
      div_start    = 1'b1;
      div_dividend = DW'(HR_AVG_DIVIDEND);
      div_divisor  = DW'(sum);
    end
  end

  seq_divider #(.DW(DW)) u_div (
    .clk      (i_clk),
    .rst_n    (i_nrst),
    .en       (i_ce),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quot)
  );

  // Control FSM, window bookkeeping and registered outputs
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      sum            <= '0;
      fill           <= '0;
      inst_q         <= '0;
      o_hr_bpm       <= '0;
      o_hr_avg_bpm   <= '0;
      o_hr_valid     <= 1'b0;
      o_hr_avg_valid <= 1'b0;
      o_brady        <= 1'b0;
      o_tachy        <= 1'b0;
      o_rr_rejected  <= 1'b0;
      o_busy         <= 1'b0;
      for (int i = 0; i < int'(NAVG); i++) rr_buf[i] <= '0;
    end else if (!i_ce) begin
      o_hr_valid    <= 1'b0;
      o_rr_rejected <= 1'b0;
    end else begin
      o_hr_valid    <= 1'b0;
      o_rr_rejected <= 1'b0;
      if (!i_alg_active) begin
        state          <= IDLE;
        o_busy         <= 1'b0;
        sum            <= '0;
        fill           <= '0;
        wr_ptr         <= '0;
        o_hr_avg_valid <= 1'b0;
        o_brady        <= 1'b0;
        o_tachy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (i_rr_period_updated) begin
              if (in_range) begin
                rr_buf[wr_ptr] <= i_rr_period;
                sum            <= sum + SW'(i_rr_period) - SW'(oldest);
                wr_ptr         <= wr_ptr + AW'(1);
                if (!full) fill <= fill + FW'(1);
                o_busy         <= 1'b1;
                state          <= DIV_INST;
              end else begin
                o_rr_rejected <= 1'b1;
              end
            end
          end
          DIV_INST: begin
            if (i_rr_period_updated) o_rr_rejected <= 1'b1;
            if (div_done) begin
              inst_q <= div_quot;
              state  <= DIV_AVG;
            end
          end
          DIV_AVG: begin
            if (i_rr_period_updated) o_rr_rejected <= 1'b1;
            if (div_done) begin
              o_hr_bpm <= sat_hr(inst_q);
              if (full) begin
                o_hr_avg_bpm   <= avg_new;
                o_hr_avg_valid <= 1'b1;
                o_brady        <= (avg_new < HR_WIDTH'(BRADY_BPM));
                o_tachy        <= (avg_new > HR_WIDTH'(TACHY_BPM));
              end
              o_hr_valid <= 1'b1;
              o_busy     <= 1'b0;
              state      <= DONE;
            end
          end
          DONE: begin
            if (i_rr_period_updated) o_rr_rejected <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hr_monitor.sv
// Scoreboard bench for hr_monitor: directed RR strobes with hand-computed
// BPM/average/alarm expectations checked by an independent output monitor.
module tb_hr_monitor;

  logic        clk = 1'b0;
  logic        i_nrst;
  logic        i_ce;
  logic [10:0] i_rr_period;
  logic        i_rr_period_updated;
  logic        i_alg_active;
  logic [8:0]  o_hr_bpm;
  logic [8:0]  o_hr_avg_bpm;
  logic        o_hr_valid;
  logic        o_hr_avg_valid;
  logic        o_brady;
  logic        o_tachy;
  logic        o_rr_rejected;
  logic        o_busy;

  typedef struct {
    int cyc;
    int bpm;
    int avg;
    int av;
    int br;
    int ta;
  } exp_t;

  exp_t hr_q[$];
  int   rej_q[$];
  int   cyc = 0;
  int   a_cyc = 0;
  int   checks = 0;
  int   errors = 0;

  hr_monitor dut (
    .i_clk               (clk),
    .i_nrst              (i_nrst),
    .i_ce                (i_ce),
    .i_rr_period         (i_rr_period),
    .i_rr_period_updated (i_rr_period_updated),
    .i_alg_active        (i_alg_active),
    .o_hr_bpm            (o_hr_bpm),
    .o_hr_avg_bpm        (o_hr_avg_bpm),
    .o_hr_valid          (o_hr_valid),
    .o_hr_avg_valid      (o_hr_avg_valid),
    .o_brady             (o_brady),
    .o_tachy             (o_tachy),
    .o_rr_rejected       (o_rr_rejected),
    .o_busy              (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: compare each presented result against the scoreboard
  always @(negedge clk) begin
    if (i_nrst) begin
      if (o_hr_valid) begin
        if (hr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hr_valid: got pulse expected none (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = hr_q.pop_front();
          chk("hr_valid_cycle", cyc, e.cyc);
          chk("hr_bpm", int'(o_hr_bpm), e.bpm);
          chk("hr_avg_bpm", int'(o_hr_avg_bpm), e.avg);
          chk("hr_avg_valid", int'(o_hr_avg_valid), e.av);
          chk("brady", int'(o_brady), e.br);
          chk("tachy", int'(o_tachy), e.ta);
          chk("busy_at_valid", int'(o_busy), 0);
        end
      end
      if (o_rr_rejected) begin
        if (rej_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_reject: got pulse expected none (cycle %0d)", cyc);
        end else begin
          chk("reject_cycle", cyc, rej_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int rr);
    i_rr_period         = 11'(rr);
    i_rr_period_updated = 1'b1;
    a_cyc               = cyc;
    tick(1);
    i_rr_period_updated = 1'b0;
  endtask

  task automatic expect_hr(input int lat, input int bpm, input int avg,
                           input int av, input int br, input int ta);
    exp_t e;
    e.cyc = a_cyc + lat;
    e.bpm = bpm;
    e.avg = avg;
    e.av  = av;
    e.br  = br;
    e.ta  = ta;
    hr_q.push_back(e);
  endtask

  task automatic good(input int rr, input int bpm, input int avg,
                      input int av, input int br, input int ta);
    strobe(rr);
    expect_hr(37, bpm, avg, av, br, ta);
    tick(40);
  endtask

  task automatic bad(input int rr);
    strobe(rr);
    rej_q.push_back(a_cyc + 1);
    tick(3);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hr_bpm"}, int'(o_hr_bpm), 0);
    chk({tag, "_hr_avg_bpm"}, int'(o_hr_avg_bpm), 0);
    chk({tag, "_hr_valid"}, int'(o_hr_valid), 0);
    chk({tag, "_hr_avg_valid"}, int'(o_hr_avg_valid), 0);
    chk({tag, "_brady"}, int'(o_brady), 0);
    chk({tag, "_tachy"}, int'(o_tachy), 0);
    chk({tag, "_rr_rejected"}, int'(o_rr_rejected), 0);
    chk({tag, "_busy"}, int'(o_busy), 0);
  endtask

  int avg150 [8] = '{76, 82, 88, 96, 104, 115, 128, 144};
  int ta150  [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
  int avg540 [8] = '{108, 87, 72, 62, 54, 48, 43, 40};
  int br540  [8] = '{0, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    i_nrst              = 1'b0;
    i_ce                = 1'b1;
    i_alg_active        = 1'b1;
    i_rr_period         = '0;
    i_rr_period_updated = 1'b0;
    tick(2);
    check_zero("reset");
    i_nrst = 1'b1;
    tick(2);

    // First beat: 21600/360 = 60, window not full
    strobe(360);
    chk("busy_after_accept", int'(o_busy), 1);
    expect_hr(37, 60, 0, 0, 0, 0);
    tick(40);

    // Clear window, then fill it with 300s
    i_alg_active = 1'b0;
    tick(1);
    i_alg_active = 1'b1;
    tick(1);
    for (int k = 0; k < 7; k++) good(300, 72, 0, 0, 0, 0);
    good(300, 72, 72, 1, 0, 0);

    // Out-of-range rejects leave the window alone
    bad(60);
    bad(1200);

    // Window drifts from 300s to 150s: tachy
    for (int k = 0; k < 8; k++) good(150, 144, avg150[k], 1, 0, ta150[k]);
    // Then to 540s: brady
    for (int k = 0; k < 8; k++) good(540, 40, avg540[k], 1, br540[k], 0);

    // Strobe while busy is rejected, running result intact (sum 4080 -> 42)
    strobe(300);
    expect_hr(37, 72, 42, 1, 1, 0);
    tick(9);
    strobe(300);
    rej_q.push_back(a_cyc + 1);
    tick(30);

    // Abort mid-computation via i_alg_active
    strobe(300);
    tick(19);
    i_alg_active = 1'b0;
    tick(1);
    i_alg_active = 1'b1;
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_avg_valid", int'(o_hr_avg_valid), 0);
    chk("abort_brady", int'(o_brady), 0);
    chk("abort_tachy", int'(o_tachy), 0);
    chk("abort_hr_bpm_hold", int'(o_hr_bpm), 72);
    tick(25);
    good(300, 72, 42, 0, 0, 0);

    // Range boundaries
    bad(71);
    bad(1081);
    good(72, 300, 42, 0, 0, 0);
    good(1080, 20, 42, 0, 0, 0);

    // Clock enable low for 5 cycles stretches latency to 42
    strobe(360);
    expect_hr(42, 60, 42, 0, 0, 0);
    tick(9);
    i_ce = 1'b0;
    tick(5);
    i_ce = 1'b1;
    tick(40);

    // Async reset during the averaged division
    strobe(300);
    tick(24);
    i_nrst = 1'b0;
    #1;
    check_zero("async_reset");
    tick(2);
    i_nrst = 1'b1;
    tick(2);
    good(360, 60, 0, 0, 0, 0);

    tick(5);
    chk("hr_queue_empty", hr_q.size(), 0);
    chk("reject_queue_empty", rej_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
